// File: rtl/irq_gateway_if.sv
// irq_gateway_if: raw lines, mode/enable controls and core
// claim/complete handshake for the interrupt gateway.
interface irq_gateway_if #(
  parameter int NUM = 4
);
  logic [NUM-1:0] irq_raw_i;
  logic [NUM-1:0] trig_edge_i;
  logic [NUM-1:0] irq_en_i;
  logic [NUM-1:0] claim_i;
  logic [NUM-1:0] complete_i;
  logic [NUM-1:0] irq_o;
  logic [NUM-1:0] claimed_o;

  modport master (
    output irq_raw_i,
    output trig_edge_i,
    output irq_en_i,
    output claim_i,
    output complete_i,
    input  irq_o,
    input  claimed_o
  );

  modport slave (
    input  irq_raw_i,
    input  trig_edge_i,
    input  irq_en_i,
    input  claim_i,
    input  complete_i,
    output irq_o,
    output claimed_o
  );
endinterface

// File: rtl/irq_gateway.sv
// irq_gateway: synchronised level/edge interrupt gateway with
// per-source pending/claimed tracking gated by core completion.
module irq_gateway #(
  parameter int NUM         = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  irq_gateway_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } state_t;

  logic [NUM-1:0] sync_q [SYNC_STAGES];
  logic [NUM-1:0] s;
  logic [NUM-1:0] s_d;
  logic [NUM-1:0] rise;
  logic [NUM-1:0] pend;
  logic [NUM-1:0] clm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      s_d <= '0;
    end else begin
      sync_q[0] <= bus.irq_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      s_d <= s;
    end
  end

  // s_d clears on reset, so a line high through reset yields one rise
  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  for (genvar i = 0; i < NUM; i++) begin : g_src
    state_t state_q;
    logic   missed_q;
    logic   edge_m;
    logic   trig;
    logic   take;

    assign edge_m = bus.trig_edge_i[i];
    assign trig   = edge_m ? rise[i] : s[i];
    assign take   = bus.claim_i[i] & bus.irq_en_i[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        missed_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (trig) state_q <= PENDING;
          end
          PENDING: begin
            if (take) begin
              state_q <= CLAIMED;
            end else if (!edge_m && !s[i]) begin
              state_q <= IDLE;
            end
          end
          CLAIMED: begin
            if (bus.complete_i[i]) begin
              missed_q <= 1'b0;
              if (missed_q || (edge_m && rise[i])) begin
                state_q <= PENDING;
              end else begin
                state_q <= IDLE;
              end
            end else if (edge_m && rise[i]) begin
              missed_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= IDLE;
            missed_q <= 1'b0;
          end
        endcase
      end
    end

    assign pend[i] = (state_q == PENDING);
    assign clm[i]  = (state_q == CLAIMED);
  end

  assign bus.irq_o     = pend & bus.irq_en_i;
  assign bus.claimed_o = clm;

endmodule

// File: tb/tb_irq_gateway.sv
// tb_irq_gateway: directed scoreboard bench for irq_gateway
// covering latency, missed edges, level withdraw, masking, reset.
module tb_irq_gateway;

  logic clk;
  logic rst_n;

  irq_gateway_if #(.NUM(4)) bus ();

  irq_gateway #(
    .NUM         (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [3:0] irq;
    logic [3:0] clm;
  } exp_t;

  exp_t sb [$];
  int   checks;
  int   failures;

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (bus.irq_o === e.irq) else begin
      failures++;
      $error("FAIL %s irq_o observed=%b expected=%b",
             e.tag, bus.irq_o, e.irq);
    end
    checks++;
    assert (bus.claimed_o === e.clm) else begin
      failures++;
      $error("FAIL %s claimed_o observed=%b expected=%b",
             e.tag, bus.claimed_o, e.clm);
    end
  endtask

  task automatic check_now(input string tag,
                           input logic [3:0] ei,
                           input logic [3:0] ec);
    sb.push_back('{tag, ei, ec});
    compare_head();
  endtask

  task automatic step(input string tag,
                      input logic [3:0] ei,
                      input logic [3:0] ec);
    sb.push_back('{tag, ei, ec});
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.irq_raw_i   = 4'b0000;
    bus.trig_edge_i = 4'b1111;
    bus.irq_en_i    = 4'b1111;
    bus.claim_i     = 4'b0000;
    bus.complete_i  = 4'b0000;

    repeat (3) tick();
    check_now("reset", 4'b0000, 4'b0000);
    rst_n = 1'b1;
    step("idle", 4'b0000, 4'b0000);

    bus.irq_raw_i = 4'b0001;
    step("e_lat0", 4'b0000, 4'b0000);
    bus.irq_raw_i = 4'b0000;
    step("e_lat1", 4'b0000, 4'b0000);
    step("e_lat2", 4'b0001, 4'b0000);
    bus.claim_i = 4'b0001;
    step("e_claim", 4'b0000, 4'b0001);
    bus.claim_i = 4'b0000;
    step("e_hold", 4'b0000, 4'b0001);
    bus.complete_i = 4'b0001;
    step("e_cmpl", 4'b0000, 4'b0000);
    bus.complete_i = 4'b0000;
    step("e_idle", 4'b0000, 4'b0000);

    bus.irq_raw_i = 4'b0100;
    step("m_s0", 4'b0000, 4'b0000);
    bus.irq_raw_i = 4'b0000;
    step("m_s1", 4'b0000, 4'b0000);
    step("m_pend", 4'b0100, 4'b0000);
    bus.claim_i = 4'b0100;
    step("m_claim", 4'b0000, 4'b0100);
    bus.claim_i   = 4'b0000;
    bus.irq_raw_i = 4'b0100;
    step("m_r0", 4'b0000, 4'b0100);
    bus.irq_raw_i = 4'b0000;
    step("m_r1", 4'b0000, 4'b0100);
    step("m_r2", 4'b0000, 4'b0100);
    bus.complete_i = 4'b0100;
    step("m_repend", 4'b0100, 4'b0000);
    bus.complete_i = 4'b0000;
    bus.irq_raw_i  = 4'b0100;
    step("m_t0", 4'b0100, 4'b0000);
    bus.irq_raw_i = 4'b0000;
    step("m_t1", 4'b0100, 4'b0000);
    step("m_t2", 4'b0100, 4'b0000);
    bus.claim_i = 4'b0100;
    step("m_claim2", 4'b0000, 4'b0100);
    bus.claim_i    = 4'b0000;
    bus.complete_i = 4'b0100;
    step("m_single", 4'b0000, 4'b0000);
    bus.complete_i = 4'b0000;
    step("m_quiet", 4'b0000, 4'b0000);

    bus.trig_edge_i = 4'b0000;
    bus.irq_raw_i   = 4'b0010;
    step("l_s0", 4'b0000, 4'b0000);
    step("l_s1", 4'b0000, 4'b0000);
    step("l_pend", 4'b0010, 4'b0000);
    bus.irq_raw_i = 4'b0000;
    step("l_f0", 4'b0010, 4'b0000);
    step("l_f1", 4'b0010, 4'b0000);
    step("l_wdraw", 4'b0000, 4'b0000);
    bus.irq_raw_i = 4'b0010;
    step("l_h0", 4'b0000, 4'b0000);
    step("l_h1", 4'b0000, 4'b0000);
    step("l_h2", 4'b0010, 4'b0000);
    bus.claim_i = 4'b0010;
    step("l_claim", 4'b0000, 4'b0010);
    bus.claim_i = 4'b0000;
    step("l_inserv", 4'b0000, 4'b0010);
    bus.complete_i = 4'b0010;
    step("l_cmpl", 4'b0000, 4'b0000);
    bus.complete_i = 4'b0000;
    step("l_reraise", 4'b0010, 4'b0000);
    bus.irq_raw_i = 4'b0000;
    step("l_d0", 4'b0010, 4'b0000);
    step("l_d1", 4'b0010, 4'b0000);
    step("l_d2", 4'b0000, 4'b0000);

    bus.trig_edge_i = 4'b1111;
    bus.irq_en_i    = 4'b0000;
    bus.irq_raw_i   = 4'b1111;
    step("k_s0", 4'b0000, 4'b0000);
    bus.irq_raw_i = 4'b0000;
    step("k_s1", 4'b0000, 4'b0000);
    step("k_masked", 4'b0000, 4'b0000);
    bus.claim_i = 4'b0001;
    step("k_claim_ign", 4'b0000, 4'b0000);
    bus.claim_i  = 4'b0000;
    bus.irq_en_i = 4'b1111;
    #1;
    check_now("k_expose", 4'b1111, 4'b0000);

    bus.claim_i = 4'b0011;
    step("p_multi", 4'b1100, 4'b0011);
    bus.claim_i    = 4'b0100;
    bus.complete_i = 4'b0100;
    step("p_clm_cmp", 4'b1000, 4'b0111);
    bus.claim_i    = 4'b0000;
    bus.complete_i = 4'b0011;
    step("p_cmp01", 4'b1000, 4'b0100);
    bus.complete_i = 4'b0100;
    step("p_cmp2", 4'b1000, 4'b0000);
    bus.complete_i = 4'b0001;
    step("p_cmp_idle", 4'b1000, 4'b0000);
    bus.complete_i = 4'b0000;
    step("p_stable", 4'b1000, 4'b0000);

    bus.claim_i = 4'b1000;
    step("r_claim", 4'b0000, 4'b1000);
    bus.claim_i   = 4'b0000;
    bus.irq_raw_i = 4'b1000;
    step("r_s0", 4'b0000, 4'b1000);
    step("r_s1", 4'b0000, 4'b1000);
    step("r_missed", 4'b0000, 4'b1000);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("r_async", 4'b0000, 4'b0000);
    tick();
    check_now("r_held", 4'b0000, 4'b0000);
    rst_n = 1'b1;
    step("r_rel0", 4'b0000, 4'b0000);
    step("r_rel1", 4'b0000, 4'b0000);
    step("r_rel2", 4'b1000, 4'b0000);
    step("r_one", 4'b1000, 4'b0000);
    bus.claim_i = 4'b1000;
    step("r_claim2", 4'b0000, 4'b1000);
    bus.claim_i    = 4'b0000;
    bus.complete_i = 4'b1000;
    step("r_nomiss", 4'b0000, 4'b0000);
    bus.complete_i = 4'b0000;
    step("r_idle", 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
